// File: rtl/pc_sequencer_if.sv
// Program-ROM fetch bus between the PC sequencer (master) and the instruction ROM (slave).
// rom_addr is {page, offset} and stays stable while rom_req is high.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int INS_W  = 16
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [INS_W-1:0]  rom_data;

  modport master (output rom_req, rom_addr, input  rom_ack, rom_data);
  modport slave  (input  rom_req, rom_addr, output rom_ack, rom_data);
endinterface

// File: rtl/pc_sequencer.sv
// Instruction fetch and {page, offset} program-counter sequencer for the 8-bit CPU.
// Fetches over the ROM req/ack bus, resolves jumps in DEC, hands other words to the datapath.
module pc_sequencer #(
  parameter int          PC_W   = 8,
  parameter int          PG_W   = 8,
  parameter int          INS_W  = 16,
  parameter int unsigned RST_PC = 0,
  parameter int unsigned RST_PG = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hold_i,
  pc_sequencer_if.master       rom,
  output logic [INS_W-1:0]     prg_o,
  output logic                 prg_vld_o,
  input  logic                 jump_i,
  input  logic                 page_i,
  input  logic                 page0_i,
  input  logic [PC_W-1:0]      tgt_i,
  input  logic [PG_W-1:0]      pgsel_i,
  output logic                 exe_start_o,
  input  logic                 exe_done_i,
  output logic [PG_W+PC_W-1:0] pc_out_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DEC,
    S_EXEC
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PG_W-1:0]   pg_q;
  logic [INS_W-1:0]  prg_q;
  logic              req_q;
  logic              vld_q;
  logic              start_q;

  logic [PC_W-1:0]   pc_inc;
  logic              is_jump;

  // Increment stays inside the current page; the page only changes on a taken jump.
  assign pc_inc  = pc_q + 1'b1;
  assign is_jump = prg_q[INS_W-1] & prg_q[INS_W-2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= PC_W'(RST_PC);
      pg_q    <= PG_W'(RST_PG);
      prg_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!hold_i) begin
            req_q   <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom.rom_ack) begin
            prg_q   <= rom.rom_data;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= S_DEC;
          end
        end
        S_DEC: begin
          if (is_jump) begin
            vld_q   <= 1'b0;
            state_q <= S_FETCH;
            if (jump_i) begin
              pc_q <= tgt_i;
              if (page_i) begin
                pg_q <= pgsel_i;
              end else if (page0_i) begin
                pg_q <= '0;
              end
            end else begin
              pc_q <= pc_inc;
            end
          end else begin
            start_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exe_done_i) begin
            pc_q    <= pc_inc;
            vld_q   <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign rom.rom_req  = req_q;
  assign rom.rom_addr = {pg_q, pc_q};
  assign prg_o        = prg_q;
  assign prg_vld_o    = vld_q;
  assign exe_start_o  = start_q;
  assign pc_out_o     = {pg_q, pc_q};

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, execute/jump flows, page wrap, ACK stall,
// mid-transaction reset and HOLD, with immediate assertions at every check point.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [15:0] prg;
  logic        prgVld;
  logic        jump;
  logic        page;
  logic        page0;
  logic [7:0]  tgt;
  logic [7:0]  pgsel;
  logic        exeStart;
  logic        exeDone;
  logic [15:0] pcOut;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if romIf ();

  pc_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .hold_i     (hold),
    .rom        (romIf),
    .prg_o      (prg),
    .prg_vld_o  (prgVld),
    .jump_i     (jump),
    .page_i     (page),
    .page0_i    (page0),
    .tgt_i      (tgt),
    .pgsel_i    (pgsel),
    .exe_start_o(exeStart),
    .exe_done_i (exeDone),
    .pc_out_o   (pcOut)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic j, input logic pg, input logic pg0,
                               input logic [7:0] t, input logic [7:0] sel);
    jump  = j;
    page  = pg;
    page0 = pg0;
    tgt   = t;
    pgsel = sel;
  endtask

  // ROM answers in the current WAIT cycle; afterwards the sequencer sits in DEC.
  task automatic ackWord(input logic [15:0] word);
    romIf.rom_ack  = 1'b1;
    romIf.rom_data = word;
    tick();
    romIf.rom_ack  = 1'b0;
    romIf.rom_data = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    exeDone = 1'b0;
    romIf.rom_ack = 1'b0;
    romIf.rom_data = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held for two cycles.
    tick();
    tick();
    checkOutput("rst_addr", romIf.rom_addr, 16'h0000);
    checkOutput("rst_req", 16'(romIf.rom_req), 16'h0000);
    checkOutput("rst_prg", prg, 16'h0000);
    checkOutput("rst_vld", 16'(prgVld), 16'h0000);
    checkOutput("rst_start", 16'(exeStart), 16'h0000);
    rst = 1'b0;
    tick();
    checkOutput("req_after_rst", 16'(romIf.rom_req), 16'h0001);
    checkOutput("addr_after_rst", romIf.rom_addr, 16'h0000);

    // Jump to 0x12FF to set up the in-page wrap case.
    ackWord(16'hC012);
    checkOutput("dec_prg", prg, 16'hC012);
    checkOutput("dec_vld", 16'(prgVld), 16'h0001);
    checkOutput("dec_req", 16'(romIf.rom_req), 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h12);
    tick();
    checkOutput("jmp_pc_12ff", pcOut, 16'h12FF);
    checkOutput("jmp_vld_clr", 16'(prgVld), 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("wait_addr_12ff", romIf.rom_addr, 16'h12FF);

    // Non-jump word, EXE_DONE three cycles after the start pulse.
    ackWord(16'h1234);
    checkOutput("nj_prg", prg, 16'h1234);
    checkOutput("nj_start_dec", 16'(exeStart), 16'h0000);
    tick();
    checkOutput("nj_start_pulse", 16'(exeStart), 16'h0001);
    tick();
    checkOutput("nj_start_low1", 16'(exeStart), 16'h0000);
    checkOutput("nj_vld_exec", 16'(prgVld), 16'h0001);
    tick();
    checkOutput("nj_start_low2", 16'(exeStart), 16'h0000);
    checkOutput("nj_pc_hold", pcOut, 16'h12FF);
    exeDone = 1'b1;
    tick();
    exeDone = 1'b0;
    checkOutput("wrap_pc", pcOut, 16'h1200);
    checkOutput("wrap_start", 16'(exeStart), 16'h0000);
    checkOutput("wrap_vld", 16'(prgVld), 16'h0000);
    tick();
    checkOutput("wrap_addr", romIf.rom_addr, 16'h1200);
    checkOutput("wrap_req", 16'(romIf.rom_req), 16'h0001);

    // Paged jump, then page-0 jump.
    ackWord(16'hC080);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h05);
    tick();
    tick();
    checkOutput("jmp_page_addr", romIf.rom_addr, 16'h0540);
    ackWord(16'hC080);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 8'h05);
    tick();
    tick();
    checkOutput("jmp_page0_addr", romIf.rom_addr, 16'h0040);

    // Move to 0x0310, then a conditional jump that is not taken.
    ackWord(16'hC000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h03);
    tick();
    tick();
    checkOutput("addr_0310", romIf.rom_addr, 16'h0310);
    ackWord(16'hC123);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 8'h09);
    tick();
    checkOutput("nt_start", 16'(exeStart), 16'h0000);
    checkOutput("nt_pc", pcOut, 16'h0311);
    tick();
    checkOutput("nt_addr", romIf.rom_addr, 16'h0311);

    // Word with only bit 14 set is not a jump even while JUMP is asserted.
    ackWord(16'h4000);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA, 8'hBB);
    tick();
    checkOutput("bit14_start", 16'(exeStart), 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    exeDone = 1'b1;
    tick();
    exeDone = 1'b0;
    checkOutput("bit14_pc", pcOut, 16'h0312);
    tick();

    // ACK delayed five cycles; HOLD during WAIT has no effect.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_req%0d", i), 16'(romIf.rom_req), 16'h0001);
      checkOutput($sformatf("stall_addr%0d", i), romIf.rom_addr, 16'h0312);
      tick();
    end
    hold = 1'b0;
    ackWord(16'hC000);
    checkOutput("stall_prg", prg, 16'hC000);
    tick();
    checkOutput("stall_next_pc", pcOut, 16'h0313);

    // Stray ACK while in FETCH must not load PRG.
    romIf.rom_ack  = 1'b1;
    romIf.rom_data = 16'hFFFF;
    tick();
    romIf.rom_ack  = 1'b0;
    romIf.rom_data = 16'h0000;
    checkOutput("stray_prg", prg, 16'hC000);
    checkOutput("stray_vld", 16'(prgVld), 16'h0000);
    checkOutput("stray_req", 16'(romIf.rom_req), 16'h0001);

    // Reset mid-WAIT, then a late ACK that must be ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rw_addr", romIf.rom_addr, 16'h0000);
    checkOutput("rw_req", 16'(romIf.rom_req), 16'h0000);
    checkOutput("rw_prg", prg, 16'h0000);
    romIf.rom_ack  = 1'b1;
    romIf.rom_data = 16'hABCD;
    tick();
    romIf.rom_ack  = 1'b0;
    romIf.rom_data = 16'h0000;
    checkOutput("rw_late_prg", prg, 16'h0000);
    checkOutput("rw_late_vld", 16'(prgVld), 16'h0000);

    // Reset mid-EXEC, late DONE ignored, HOLD keeps the sequencer in FETCH.
    ackWord(16'h1111);
    tick();
    checkOutput("re_start", 16'(exeStart), 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("re_pc", pcOut, 16'h0000);
    checkOutput("re_start_clr", 16'(exeStart), 16'h0000);
    checkOutput("re_vld", 16'(prgVld), 16'h0000);
    checkOutput("re_prg", prg, 16'h0000);
    exeDone = 1'b1;
    hold = 1'b1;
    tick();
    exeDone = 1'b0;
    checkOutput("hold_req0", 16'(romIf.rom_req), 16'h0000);
    checkOutput("hold_pc0", pcOut, 16'h0000);
    tick();
    checkOutput("hold_req1", 16'(romIf.rom_req), 16'h0000);
    hold = 1'b0;
    tick();
    checkOutput("unhold_req", 16'(romIf.rom_req), 16'h0001);
    checkOutput("unhold_addr", romIf.rom_addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
